// File: rtl/if_pc_ctrl.sv
// Fetch-stage program counter owner.
// Holds the PC, offers PC+PC_INC and the selected redirect target to the IF
// next-PC mux, gates PC advance by run/step mode and hazard stall, detects the
// HALT encoding and counts advanced cycles for the debug unit.
//
// Handshake note: there is no valid/ready pair here. A redirect request
// (i_jump / i_branch_taken) is consumed only on a cycle with o_pc_en=1; while
// i_stall is high it is ignored, so the requester must hold it until a
// non-stalled advancing cycle.
module if_pc_ctrl #(
    parameter int unsigned             SIZE_REG_MEM = 32,
    parameter int unsigned             PC_INC       = 4,
    parameter logic [SIZE_REG_MEM-1:0] HALT_INSTR   = '1,
    parameter int unsigned             SIZE_CNT     = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    input  logic                    i_mode_cont,
    input  logic                    i_step,
    input  logic                    i_clear,
    input  logic                    i_stall,
    input  logic                    i_jump,
    input  logic [SIZE_REG_MEM-1:0] i_jump_target,
    input  logic                    i_branch_taken,
    input  logic [SIZE_REG_MEM-1:0] i_branch_target,
    input  logic [SIZE_REG_MEM-1:0] i_instr,
    output logic [SIZE_REG_MEM-1:0] o_pc,
    output logic [SIZE_REG_MEM-1:0] o_pc_inc,
    output logic [SIZE_REG_MEM-1:0] o_redirect_tgt,
    output logic                    o_mux_sel,
    output logic                    o_pc_en,
    output logic                    o_halted,
    output logic [SIZE_CNT-1:0]     o_cycle_cnt,
    output logic [1:0]              o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic                    adv;
    logic                    redirect;
    logic                    halt_det;
    logic [SIZE_REG_MEM-1:0] pc_load;

    // Datapath toward the next-PC mux; the sum wraps naturally at the width.
    always_comb begin
        o_pc_inc       = o_pc + SIZE_REG_MEM'(PC_INC);
        redirect       = i_jump | i_branch_taken;
        o_redirect_tgt = i_jump ? i_jump_target : i_branch_target;
        o_mux_sel      = redirect;
        pc_load        = redirect ? o_redirect_tgt : o_pc_inc;
    end

    // Advance gating and halt detection; a halt in the redirect shadow is squashed.
    always_comb begin
        adv      = (state == ST_RUN) | ((state == ST_STEP) & i_step);
        o_pc_en  = adv & ~i_stall;
        halt_det = (i_instr == HALT_INSTR) & ~redirect;
    end

    // Next-state logic: start only leaves IDLE, clear only leaves HALT.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_start) state_nxt = i_mode_cont ? ST_RUN : ST_STEP;
            ST_RUN,
            ST_STEP: if (halt_det & o_pc_en) state_nxt = ST_HALT;
            ST_HALT: if (i_clear) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // PC register: load word-aligned next PC unless halting; clear zeroes it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pc <= '0;
        end else if ((state == ST_HALT) && i_clear) begin
            o_pc <= '0;
        end else if (o_pc_en && !halt_det) begin
            o_pc <= {pc_load[SIZE_REG_MEM-1:2], 2'b00};
        end
    end

    // Advanced-cycle counter, saturating; the halting cycle still counts.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_cycle_cnt <= '0;
        end else if ((state == ST_HALT) && i_clear) begin
            o_cycle_cnt <= '0;
        end else if (o_pc_en && (o_cycle_cnt != '1)) begin
            o_cycle_cnt <= o_cycle_cnt + 1'b1;
        end
    end

    // Debug view of the FSM.
    always_comb begin
        o_state  = state;
        o_halted = (state == ST_HALT);
    end

endmodule
